seg7_scan_mux: RTL and testbench

Eight-digit time-multiplexed scanner for the 32-bit seven-segment display core. Latches a 32-bit value and drives one 4-bit nibble at a time into the binary-to-7-segment converter. Generates the matching active-low anode enables, with a blanking gap between digits to suppress ghosting. The value is double-buffered so a displayed frame never mixes old and new digits.

---
 rtl/seg7_scan_mux.sv | 121 ++++++++++++
 tb/tb_seg7_scan_mux.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Eight-digit time-multiplexed scanner for a seven-segment display.
// Optional leading-zero suppression: define SEG7_SCAN_LZ_BLANK_EN.
module seg7_scan_mux #(
   parameter int CLK_DIV   = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value_in,
   input  logic        load,
   input  logic [7:0]  digit_en_in,
   output logic [3:0]  bin_out,
   output logic [7:0]  an_out,
   output logic [2:0]  digit_idx,
   output logic        frame_start
);

   localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
   localparam int DW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [DW-1:0] BLAST = DW'(BLANK_CYC - 1);
   localparam logic [DW-1:0] SLAST = DW'(CLK_DIV - 1);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic [2:0]     idx_q, idx_d;
   logic [31:0]    pend_q, pend_d;
   logic [31:0]    shad_q, shad_d;
   logic [7:0]     an_q, an_d;
   logic [3:0]     bin_q, bin_d;
   logic           fs_q, fs_d;
   logic           lz_ok;
   logic           lit;
   logic [31:0]    nib_sh;

   // Leading-zero qualifier for the current slot.
`ifdef SEG7_SCAN_LZ_BLANK_EN
   always_comb begin
      lz_ok = (idx_q == 3'd0) ||
              ((shad_q >> {idx_q, 2'b00}) != 32'd0);
   end
`else
   always_comb begin
      lz_ok = 1'b1;
   end
`endif

   // Next-state: slot sequencing, double buffer, registered outputs.
   always_comb begin
      state_d = state_q;
      div_d   = div_q + 1'b1;
      idx_d   = idx_q;
      pend_d  = load ? value_in : pend_q;
      shad_d  = shad_q;
      an_d    = an_q;
      bin_d   = bin_q;
      fs_d    = 1'b0;
      nib_sh  = 32'd0;
      lit     = digit_en_in[idx_q] & lz_ok;
      case (state_q)
         BLANK: begin
            if (div_q == BLAST) begin
               state_d = SHOW;
               div_d   = '0;
               an_d    = lit ? ~(8'b1 << idx_q) : 8'hFF;
            end
         end
         SHOW: begin
            if (div_q == SLAST) begin
               state_d = BLANK;
               div_d   = '0;
               idx_d   = idx_q + 3'd1;
               an_d    = 8'hFF;
               if (idx_q == 3'd7) begin
                  shad_d = pend_d;
                  fs_d   = 1'b1;
               end
               nib_sh = shad_d >> {idx_d, 2'b00};
               bin_d  = nib_sh[3:0];
            end
         end
         default: begin
            state_d = BLANK;
            div_d   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BLANK;
         div_q   <= '0;
         idx_q   <= 3'd0;
         pend_q  <= 32'd0;
         shad_q  <= 32'd0;
         an_q    <= 8'hFF;
         bin_q   <= 4'h0;
         fs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         shad_q  <= shad_d;
         an_q    <= an_d;
         bin_q   <= bin_d;
         fs_q    <= fs_d;
      end
   end

   assign an_out      = an_q;
   assign bin_out     = bin_q;
   assign digit_idx   = idx_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with CLK_DIV=4, BLANK_CYC=2.
// Cycle-indexed reference model of slots, frames and buffering.
module tb_seg7_scan_mux;

   localparam int SHOWC = 4;
   localparam int BLNKC = 2;
   localparam int SLOT  = SHOWC + BLNKC;
   localparam int FRAME = 8 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] value_in = 32'd0;
   logic        load = 1'b0;
   logic [7:0]  digit_en_in = 8'hFF;
   logic [3:0]  bin_out;
   logic [7:0]  an_out;
   logic [2:0]  digit_idx;
   logic        frame_start;

   int n_chk  = 0;
   int n_fail = 0;
   int t = 0;
   logic [31:0] m_pend = 32'd0;
   logic [31:0] m_shown = 32'd0;
   bit          m_en = 1'b0;

   seg7_scan_mux #(.CLK_DIV(SHOWC), .BLANK_CYC(BLNKC)) dut (
      .clk(clk),
      .rst(rst),
      .value_in(value_in),
      .load(load),
      .digit_en_in(digit_en_in),
      .bin_out(bin_out),
      .an_out(an_out),
      .digit_idx(digit_idx),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
      end
   endtask

   function automatic bit lz_ok(input logic [31:0] v, input int d);
`ifdef SEG7_SCAN_LZ_BLANK_EN
      return (d == 0) || ((v >> (4 * d)) != 32'd0);
`else
      return 1'b1;
`endif
   endfunction

   // Check one cycle against the model, then advance one clock.
   task automatic step();
      int ph, d;
      logic [7:0] e_an;
      logic [31:0] nb;
      ph = t % SLOT;
      d  = (t % FRAME) / SLOT;
      e_an = (ph < BLNKC || !m_en) ? 8'hFF : ~(8'h01 << d);
      nb = m_shown >> (4 * d);
      chk("an", an_out, e_an);
      chk("bin", bin_out, nb & 32'hF);
      chk("idx", digit_idx, d);
      chk("fs", frame_start, (t % FRAME) == 0);
      if (ph == BLNKC - 1)
         m_en = digit_en_in[d] && lz_ok(m_shown, d);
      if (load)
         m_pend = value_in;
      if ((t % FRAME) == FRAME - 1)
         m_shown = m_pend;
      t++;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic run(input int n, input bit rl, input bit rm);
      for (int i = 0; i < n; i++) begin
         if (rl && $urandom_range(0, 9) == 0) begin
            load = 1'b1;
            value_in = $urandom;
         end
         if (rm && $urandom_range(0, 4) == 0)
            digit_en_in = 8'($urandom);
         step();
      end
   endtask

   task automatic run_to(input int ph);
      for (int i = 0; i < FRAME && (t % FRAME) != ph; i++)
         step();
   endtask

   task automatic do_load(input logic [31:0] v);
      load = 1'b1;
      value_in = v;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_an", an_out, 8'hFF);
      chk("rst_fs", frame_start, 1'b1);
      rst = 1'b0;

      // Scan order with a known value.
      do_load(32'h12345678);
      run(2 * FRAME, 1'b0, 1'b0);

      // No tearing: load mid-frame during digit 4.
      do_load(32'h11111111);
      run_to(0);
      run_to(4 * SLOT + 3);
      do_load(32'h22222222);
      run(FRAME, 1'b0, 1'b0);

      // Load coinciding with the frame boundary.
      run_to(FRAME - 1);
      do_load(32'h33333333);
      run(FRAME, 1'b0, 1'b0);

      // Mask keeps upper digits dark.
      digit_en_in = 8'h0F;
      run(FRAME, 1'b0, 1'b0);
      digit_en_in = 8'hFF;

      // Leading-zero candidates.
      run_to(FRAME - 1);
      do_load(32'h00000A05);
      run(FRAME + 1, 1'b0, 1'b0);
      run_to(FRAME - 1);
      do_load(32'h0);
      run(FRAME + 1, 1'b0, 1'b0);

      // Random loads and mask changes.
      run(20 * FRAME, 1'b1, 1'b1);
      digit_en_in = 8'hFF;
      do_load(32'hCAFEBABE);
      run(FRAME, 1'b0, 1'b0);

      // Asynchronous reset mid-SHOW of digit 3.
      run_to(3 * SLOT + 3);
      rst = 1'b1;
      #1;
      chk("arst_an", an_out, 8'hFF);
      chk("arst_bin", bin_out, 4'h0);
      chk("arst_idx", digit_idx, 3'd0);
      chk("arst_fs", frame_start, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      t = 0;
      m_pend = 32'd0;
      m_shown = 32'd0;
      m_en = 1'b0;
      run(2 * FRAME, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
